// File: rtl/outser_pkg.sv
// Shared definitions for the AXI-Stream output serializer.
// Contents:
//   sum_width()  - width of one PE result lane.
//   wide_width() - width of one wide result word (all lanes).
//   ceil_div()   - rounded-up integer division, used to size the beat count.
//   ST_IDLE / ST_SEND - serializer FSM state encoding.
package outser_pkg;

    // Width of one accumulated lane: pixel * weight product plus kernel growth bits.
    function automatic int sum_width(input int data_w, input int weight_w, input int kernel);
        return data_w + weight_w + kernel;
    endfunction

    // Width of the wide word carrying all KERNEL_SIZE lanes side by side.
    function automatic int wide_width(input int data_w, input int weight_w, input int kernel);
        return sum_width(data_w, weight_w, kernel) * kernel;
    endfunction

    // Integer division rounded up.
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

endpackage

// File: rtl/axis_beat_select.sv
// Combinational beat extractor for the output serializer.
// Build option: OUTSER_LANE_ALIGN_EN
//   undefined - dense packing: beat k = bits [k*BUS_WIDTH +: BUS_WIDTH] of the
//               word, zero-padded above the word width.
//   defined   - lane aligned: beat k = lane k sign-extended to BUS_WIDTH.
// Ports:
//   word - wide result word (KERNEL_SIZE lanes of SUM_WIDTH bits).
//   beat - beat index to present.
//   data - selected BUS_WIDTH-bit beat; zero for an index beyond BEATS-1.
module axis_beat_select #(
    parameter int SUM_WIDTH   = 19,
    parameter int KERNEL_SIZE = 3,
    parameter int BUS_WIDTH   = 32,
    parameter int BEATS       = 2,
    parameter int BEAT_W      = 1
) (
    input  logic [SUM_WIDTH*KERNEL_SIZE-1:0] word,
    input  logic [BEAT_W-1:0]                beat,
    output logic [BUS_WIDTH-1:0]             data
);

    logic [BUS_WIDTH-1:0] slices [BEATS];

`ifdef OUTSER_LANE_ALIGN_EN
    if (SUM_WIDTH > BUS_WIDTH) begin : g_lane_too_wide
        $error("axis_beat_select: SUM_WIDTH exceeds BUS_WIDTH in lane-aligned mode");
    end

    // The size cast of a signed operand sign-extends each lane to the bus width.
    for (genvar k = 0; k < BEATS; k++) begin : g_lane
        assign slices[k] = BUS_WIDTH'($signed(word[k*SUM_WIDTH +: SUM_WIDTH]));
    end
`else
    localparam int PAD_W = BEATS * BUS_WIDTH;

    logic [PAD_W-1:0] padded;

    // Zero extension supplies the padding of the final, partially filled beat.
    assign padded = PAD_W'(word);

    for (genvar k = 0; k < BEATS; k++) begin : g_dense
        assign slices[k] = padded[k*BUS_WIDTH +: BUS_WIDTH];
    end
`endif

    // Beat multiplexer; indices past the last beat read as zero.
    always_comb begin
        data = {BUS_WIDTH{1'b0}};
        if ({1'b0, beat} < (BEAT_W + 1)'(BEATS)) begin
            data = slices[beat];
        end else begin
            data = {BUS_WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/axis_output_serializer.sv
// AXI-Stream output serializer: takes one wide PE result word from the output
// FIFO and sends it as BEATS bus-width beats toward the DMA, LSB first.
// m_axis_tlast marks the last beat of the last word of each FRAME_WORDS frame.
// Build option: OUTSER_LANE_ALIGN_EN (one sign-extended lane per beat).
// Ports:
//   clk, rst        - clock, asynchronous active-high reset.
//   s_axis_*        - wide word input (tdata, tvalid, tready).
//   m_axis_*        - outgoing beat stream (tdata, tvalid, tready, tlast).
//   busy            - a word is held and being sent.
module axis_output_serializer
    import outser_pkg::*;
#(
    parameter int KERNEL_SIZE  = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int BUS_WIDTH    = 32,
    parameter int FRAME_WORDS  = 14
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic [wide_width(DATA_WIDTH, WEIGHT_WIDTH, KERNEL_SIZE)-1:0] s_axis_tdata,
    input  logic                                                    s_axis_tvalid,
    output logic                                                    s_axis_tready,
    output logic [BUS_WIDTH-1:0]                                    m_axis_tdata,
    output logic                                                    m_axis_tvalid,
    input  logic                                                    m_axis_tready,
    output logic                                                    m_axis_tlast,
    output logic                                                    busy
);

    localparam int SUM_W  = sum_width(DATA_WIDTH, WEIGHT_WIDTH, KERNEL_SIZE);
    localparam int WIDE_W = wide_width(DATA_WIDTH, WEIGHT_WIDTH, KERNEL_SIZE);
`ifdef OUTSER_LANE_ALIGN_EN
    localparam int BEATS  = KERNEL_SIZE;
`else
    localparam int BEATS  = ceil_div(WIDE_W, BUS_WIDTH);
`endif
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WORD_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(FRAME_WORDS - 1);

    logic [0:0]           state;
    logic [0:0]           state_next;
    logic [BEAT_W-1:0]    beat;
    logic [BEAT_W-1:0]    beat_next;
    logic [WORD_W-1:0]    word_cnt;
    logic [WORD_W-1:0]    word_next;
    logic [WIDE_W-1:0]    hold;
    logic [WIDE_W-1:0]    hold_next;
    logic [BUS_WIDTH-1:0] sel_data;
    logic                 tvalid_next;
    logic                 tlast_next;
    logic                 data_load;
    logic                 handshake;
    logic                 last_beat;

    assign handshake = m_axis_tvalid && m_axis_tready;
    assign last_beat = (beat == LAST_BEAT);

    // A new word is taken when idle or in the same cycle the final beat leaves,
    // which removes the bubble between consecutive words.
    assign s_axis_tready = !rst && ((state == ST_IDLE) || (handshake && last_beat));

    // Next-state, counter and holding-register update for the serializer FSM.
    always_comb begin
        state_next  = state;
        beat_next   = beat;
        word_next   = word_cnt;
        hold_next   = hold;
        tvalid_next = m_axis_tvalid;
        data_load   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s_axis_tvalid) begin
                    state_next  = ST_SEND;
                    hold_next   = s_axis_tdata;
                    beat_next   = {BEAT_W{1'b0}};
                    tvalid_next = 1'b1;
                    data_load   = 1'b1;
                end else begin
                    tvalid_next = 1'b0;
                end
            end
            ST_SEND: begin
                if (handshake && !last_beat) begin
                    beat_next = beat + BEAT_W'(1);
                    data_load = 1'b1;
                end else if (handshake) begin
                    word_next = (word_cnt == LAST_WORD) ? {WORD_W{1'b0}} : word_cnt + WORD_W'(1);
                    if (s_axis_tvalid) begin
                        hold_next = s_axis_tdata;
                        beat_next = {BEAT_W{1'b0}};
                        data_load = 1'b1;
                    end else begin
                        state_next  = ST_IDLE;
                        tvalid_next = 1'b0;
                    end
                end else begin
                    // Stalled: beat, data and tlast stay exactly as they are.
                    state_next = ST_SEND;
                end
            end
            default: begin
                state_next  = ST_IDLE;
                tvalid_next = 1'b0;
            end
        endcase
    end

    // tlast is derived from the beat/word that will be on the bus next cycle.
    assign tlast_next = tvalid_next && (beat_next == LAST_BEAT) && (word_next == LAST_WORD);

    axis_beat_select #(
        .SUM_WIDTH   (SUM_W),
        .KERNEL_SIZE (KERNEL_SIZE),
        .BUS_WIDTH   (BUS_WIDTH),
        .BEATS       (BEATS),
        .BEAT_W      (BEAT_W)
    ) u_beat_select (
        .word (hold_next),
        .beat (beat_next),
        .data (sel_data)
    );

    // State, counters, holding register and registered stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            beat          <= {BEAT_W{1'b0}};
            word_cnt      <= {WORD_W{1'b0}};
            hold          <= {WIDE_W{1'b0}};
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= {BUS_WIDTH{1'b0}};
            busy          <= 1'b0;
        end else begin
            state         <= state_next;
            beat          <= beat_next;
            word_cnt      <= word_next;
            hold          <= hold_next;
            m_axis_tvalid <= tvalid_next;
            m_axis_tlast  <= tlast_next;
            busy          <= tvalid_next;
            if (data_load) begin
                m_axis_tdata <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_axis_output_serializer.sv
// Self-checking bench for axis_output_serializer (default and
// OUTSER_LANE_ALIGN_EN builds). A second instance with FRAME_WORDS=2 covers
// reset in the middle of a word.
module tb_axis_output_serializer;

`ifdef OUTSER_LANE_ALIGN_EN
    localparam int TB_BEATS = 3;
`else
    localparam int TB_BEATS = 2;
`endif

    logic        clk;
    logic        rst;
    logic [56:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        busy;

    logic        rst2;
    logic [56:0] s2_tdata;
    logic        s2_tvalid;
    logic        s2_tready;
    logic [31:0] m2_tdata;
    logic        m2_tvalid;
    logic        m2_tready;
    logic        m2_tlast;
    logic        busy2;

    int checks = 0;
    int errors = 0;
    int wc_model = 0;
    int mon_beats = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_exp;

    axis_output_serializer #(.FRAME_WORDS(14)) u_dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .busy(busy)
    );

    axis_output_serializer #(.FRAME_WORDS(2)) u_dut2 (
        .clk(clk), .rst(rst2),
        .s_axis_tdata(s2_tdata), .s_axis_tvalid(s2_tvalid), .s_axis_tready(s2_tready),
        .m_axis_tdata(m2_tdata), .m_axis_tvalid(m2_tvalid), .m_axis_tready(m2_tready),
        .m_axis_tlast(m2_tlast), .busy(busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference beat k of a wide word.
    function automatic logic [31:0] beat_of(input logic [56:0] w, input int k);
`ifdef OUTSER_LANE_ALIGN_EN
        logic [18:0] lane;
        lane = w[k*19 +: 19];
        return {{13{lane[18]}}, lane};
`else
        logic [63:0] p;
        p = {7'b0, w};
        return p[k*32 +: 32];
`endif
    endfunction

    // Push the expected beats of an accepted word (FRAME_WORDS=14 instance).
    task automatic push_word(input logic [56:0] w);
        for (int k = 0; k < TB_BEATS; k++) begin
            exp_q.push_back({(k == TB_BEATS - 1 && wc_model == 13) ? 1'b1 : 1'b0, beat_of(w, k)});
        end
        wc_model = (wc_model == 13) ? 0 : wc_model + 1;
    endtask

    // Offer a word to u_dut until accepted; scoreboard entry made on acceptance.
    task automatic drive_word(input logic [56:0] w, output bit ok);
        s_tdata  = w;
        s_tvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (s_tready) begin
                push_word(w);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Offer a word to u_dut2 until accepted.
    task automatic drive_word2(input logic [56:0] w, output bit ok);
        s2_tdata  = w;
        s2_tvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = s2_tready;
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard comparator for u_dut: every handshaken beat is popped and checked.
    always @(negedge clk) begin
        if (m_tvalid && m_tready) begin
            mon_beats++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_beat got data=%h last=%b expected none", m_tdata, m_tlast);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({m_tlast, m_tdata} !== mon_exp) begin
                    errors++;
                    $display("FAIL sb_beat got last=%b data=%h expected last=%b data=%h",
                             m_tlast, m_tdata, mon_exp[32], mon_exp[31:0]);
                end
            end
        end
    end

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d pending beats expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready got %b expected 0", s_tready); end
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid got %b expected 0", m_tvalid); end
        checks++; if (m_tdata !== 32'h0) begin errors++; $display("FAIL rst_m_tdata got %h expected 0", m_tdata); end
        checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL rst_m_tlast got %b expected 0", m_tlast); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b expected 0", busy); end
        rst  = 1'b0;
        rst2 = 1'b0;
        @(negedge clk);
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL idle_s_tready got %b expected 1", s_tready); end
    endtask

    task automatic test_dense();
        logic [56:0] w;
        logic [31:0] exp_k [3];
        bit ok;
`ifdef OUTSER_LANE_ALIGN_EN
        w = {19'h40000, 19'h00005, 19'h7FFFF};
        exp_k[0] = 32'hFFFF_FFFF; exp_k[1] = 32'h0000_0005; exp_k[2] = 32'hFFFC_0000;
`else
        w = 57'h0AB_CDEF_1234_5678;
        exp_k[0] = 32'h1234_5678; exp_k[1] = 32'h00AB_CDEF; exp_k[2] = 32'h0;
`endif
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        drive_word(w, ok);
        s_tvalid = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL dense_accept got timeout expected accept"); end
        for (int k = 0; k < TB_BEATS; k++) begin
            @(negedge clk);
            checks++;
            if (m_tdata !== exp_k[k] || m_tvalid !== 1'b1) begin
                errors++;
                $display("FAIL dense_beat%0d got data=%h valid=%b expected data=%h valid=1", k, m_tdata, m_tvalid, exp_k[k]);
            end
            checks++;
            if (s_tready !== (k == TB_BEATS - 1)) begin
                errors++;
                $display("FAIL dense_s_tready%0d got %b expected %b", k, s_tready, (k == TB_BEATS - 1));
            end
        end
        @(negedge clk);
        checks++; if (m_tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL dense_idle got valid=%b busy=%b expected 0 0", m_tvalid, busy); end
        wait_drain("dense");
    endtask

    task automatic test_backpressure();
        logic [56:0] wa;
        logic [56:0] wc;
        int start_beats;
        bit ok;
        wa = 57'h0AB_CDEF_1234_5678;
        wc = 57'h1F0_0F0F_F0F0_A5A5;
        @(posedge clk);
        #1;
        m_tready = 1'b0;
        start_beats = mon_beats;
        drive_word(wa, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_accept got timeout expected accept"); end
        s_tdata = wc;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (m_tdata !== beat_of(wa, 0) || m_tvalid !== 1'b1 || s_tready !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall%0d got data=%h valid=%b s_tready=%b expected data=%h valid=1 s_tready=0",
                         i, m_tdata, m_tvalid, s_tready, beat_of(wa, 0));
            end
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        drive_word(wc, ok);
        s_tvalid = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL bp_accept2 got timeout expected accept"); end
        wait_drain("bp");
        @(negedge clk);
        checks++;
        if (mon_beats - start_beats != 2 * TB_BEATS) begin
            errors++;
            $display("FAIL bp_beat_count got %0d expected %0d", mon_beats - start_beats, 2 * TB_BEATS);
        end
    endtask

    task automatic test_back_to_back();
        int seen;
        int idle;
        int lastpos[$];
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wc_model = 0;
        m_tready = 1'b1;
        seen = 0;
        idle = 0;
        fork
            begin
                for (int n = 0; n < 28; n++) begin
                    logic [56:0] w;
                    bit ok;
                    w = 57'({$urandom(), $urandom()});
                    drive_word(w, ok);
                    checks++;
                    if (!ok) begin errors++; $display("FAIL b2b_accept%0d got timeout expected accept", n); end
                end
                s_tvalid = 1'b0;
            end
            begin
                for (int c = 0; c < 400 && seen < 28 * TB_BEATS; c++) begin
                    @(negedge clk);
                    if (m_tvalid && m_tready) begin
                        seen++;
                        if (m_tlast) lastpos.push_back(seen);
                    end else if (seen > 0) begin
                        idle++;
                    end
                end
            end
        join
        checks++; if (seen != 28 * TB_BEATS) begin errors++; $display("FAIL b2b_beats got %0d expected %0d", seen, 28 * TB_BEATS); end
        checks++; if (idle != 0) begin errors++; $display("FAIL b2b_idle got %0d expected 0", idle); end
        checks++;
        if (lastpos.size() != 2) begin
            errors++;
            $display("FAIL b2b_tlast_count got %0d expected 2", lastpos.size());
        end else if (lastpos[0] != 14 * TB_BEATS || lastpos[1] != 28 * TB_BEATS) begin
            errors++;
            $display("FAIL b2b_tlast_pos got %0d,%0d expected %0d,%0d", lastpos[0], lastpos[1], 14 * TB_BEATS, 28 * TB_BEATS);
        end
        wait_drain("b2b");
    endtask

    task automatic test_reset_mid();
        logic [56:0] wx;
        logic [56:0] wy;
        logic [56:0] wz;
        logic [32:0] got[$];
        bit ok;
        wx = 57'h155_5555_AAAA_AAAA;
        wy = 57'h0123_4567_89AB_CDEF;
        wz = 57'h1FE_DCBA_9876_5432;
        @(posedge clk);
        #1;
        m2_tready = 1'b1;
        drive_word2(wx, ok);
        s2_tvalid = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL mid_accept got timeout expected accept"); end
        @(posedge clk);
        #1;
        rst2 = 1'b1;
        #1;
        checks++;
        if (m2_tvalid !== 1'b0 || m2_tdata !== 32'h0 || m2_tlast !== 1'b0 || busy2 !== 1'b0 || s2_tready !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_outputs got valid=%b data=%h last=%b busy=%b s_tready=%b expected all 0",
                     m2_tvalid, m2_tdata, m2_tlast, busy2, s2_tready);
        end
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        fork
            begin
                drive_word2(wy, ok);
                checks++; if (!ok) begin errors++; $display("FAIL mid_accept_y got timeout expected accept"); end
                drive_word2(wz, ok);
                checks++; if (!ok) begin errors++; $display("FAIL mid_accept_z got timeout expected accept"); end
                s2_tvalid = 1'b0;
            end
            begin
                for (int c = 0; c < 100 && got.size() < 2 * TB_BEATS; c++) begin
                    @(negedge clk);
                    if (m2_tvalid && m2_tready) got.push_back({m2_tlast, m2_tdata});
                end
            end
        join
        checks++;
        if (got.size() != 2 * TB_BEATS) begin
            errors++;
            $display("FAIL mid_beats got %0d expected %0d", got.size(), 2 * TB_BEATS);
        end else begin
            for (int k = 0; k < 2 * TB_BEATS; k++) begin
                logic [32:0] e;
                e = {(k == 2 * TB_BEATS - 1) ? 1'b1 : 1'b0,
                     beat_of((k < TB_BEATS) ? wy : wz, k % TB_BEATS)};
                checks++;
                if (got[k] !== e) begin
                    errors++;
                    $display("FAIL mid_beat%0d got last=%b data=%h expected last=%b data=%h",
                             k, got[k][32], got[k][31:0], e[32], e[31:0]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        rst2 = 1'b0;
        s_tdata = 57'h0;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        s2_tdata = 57'h0;
        s2_tvalid = 1'b0;
        m2_tready = 1'b0;
        #2;
        rst = 1'b1;
        rst2 = 1'b1;
        test_reset();
        test_dense();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
